// File: rtl/conv_extend_pipe.sv
// rtl/conv_extend_pipe.sv - two-stage handshaked zero/sign extend and saturate pipeline
module conv_extend_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int SAT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] sat_cnt
);

    // Clamp limits held at IN_W so comparisons stay in the input's own width.
    localparam logic [IN_W-1:0] U_MAX = {IN_W{1'b1}} >> (IN_W - SAT_W);
    localparam logic [IN_W-1:0] S_MAX = U_MAX >> 1;
    localparam logic [IN_W-1:0] S_MIN = ~S_MAX;

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_data_q, s1_data_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    logic             s2_load;
    logic             s1_load;
    logic             out_hs;
    logic [OUT_W-1:0] conv_data;
    logic             conv_sat;

    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign s1_load  = ~s1_valid_q | s2_load;
    assign out_hs   = out_valid_q & out_ready;

    assign in_ready  = s1_load;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign sat_cnt   = sat_cnt_q;

    always_comb begin
        conv_data = '0;
        conv_sat  = 1'b0;
        case (s1_mode_q)
            2'b00: conv_data = OUT_W'(s1_data_q);
            2'b01: conv_data = OUT_W'($signed(s1_data_q));
            2'b10: begin
                if (s1_data_q > U_MAX) begin
                    conv_data = OUT_W'(U_MAX);
                    conv_sat  = 1'b1;
                end else begin
                    conv_data = OUT_W'(s1_data_q);
                end
            end
            default: begin
                // An in-range value sign-extends identically from IN_W or SAT_W.
                if ($signed(s1_data_q) > $signed(S_MAX)) begin
                    conv_data = OUT_W'($signed(S_MAX));
                    conv_sat  = 1'b1;
                end else if ($signed(s1_data_q) < $signed(S_MIN)) begin
                    conv_data = OUT_W'($signed(S_MIN));
                    conv_sat  = 1'b1;
                end else begin
                    conv_data = OUT_W'($signed(s1_data_q));
                end
            end
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = in_mode;
            end
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            out_data_d  = conv_data;
            out_sat_d   = conv_sat;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle handshake; sat_cnt sticks at all-ones.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        if (clr_cnt) begin
            xfer_cnt_d = '0;
            sat_cnt_d  = '0;
        end else if (out_hs) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            if (out_sat_q && !(&sat_cnt_q)) begin
                sat_cnt_d = sat_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            xfer_cnt_q  <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            xfer_cnt_q  <= xfer_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_conv_extend_pipe.sv
// tb/tb_conv_extend_pipe.sv - scoreboard bench for conv_extend_pipe
module tb_conv_extend_pipe;

    localparam int IN_W  = 8;
    localparam int OUT_W = 32;
    localparam int SAT_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             clr_cnt;
    logic [CNT_W-1:0] xfer_cnt;
    logic [CNT_W-1:0] sat_cnt;

    logic             in_ready2;
    logic             out_valid2;
    logic [OUT_W-1:0] out_data2;
    logic             out_sat2;
    logic [1:0]       xfer_cnt2;
    logic [1:0]       sat_cnt2;

    always #5 clk = ~clk;

    conv_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT_W(SAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .clr_cnt(clr_cnt), .xfer_cnt(xfer_cnt), .sat_cnt(sat_cnt)
    );

    conv_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT_W(SAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2),
        .clr_cnt(clr_cnt), .xfer_cnt(xfer_cnt2), .sat_cnt(sat_cnt2)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    longint      mon_xfer = 0;
    longint      mon_sat  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [OUT_W-1:0] d, input logic s, input bit lat);
        exp_t e;
        e.data = d;
        e.sat  = s;
        e.cyc  = 0;
        e.lat  = lat;
        return e;
    endfunction

    // Reference: plain integer arithmetic on the conversion rules.
    function automatic exp_t ref_conv(input logic [IN_W-1:0] d, input logic [1:0] m);
        longint u, s, r, umax, smax, smin;
        logic   st;
        u    = longint'(d);
        s    = (u >= (longint'(1) << (IN_W - 1))) ? u - (longint'(1) << IN_W) : u;
        umax = (longint'(1) << SAT_W) - 1;
        smax = (longint'(1) << (SAT_W - 1)) - 1;
        smin = -(longint'(1) << (SAT_W - 1));
        st   = 1'b0;
        case (m)
            2'd0: r = u;
            2'd1: r = s;
            2'd2: begin
                r = u;
                if (u > umax) begin r = umax; st = 1'b1; end
            end
            default: begin
                r = s;
                if (s > smax) begin r = smax; st = 1'b1; end
                else if (s < smin) begin r = smin; st = 1'b1; end
            end
        endcase
        return mk(OUT_W'(r), st, 1'b0);
    endfunction

    task automatic push(input exp_t e);
        exp_t t;
        t = e;
        t.cyc = cyc;
        sbq.push_back(t);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", {63'd0, out_valid}, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("out_data", {32'd0, out_data}, {32'd0, mon_e.data});
                    chk("out_sat", {63'd0, out_sat}, {63'd0, mon_e.sat});
                    chk("out_data_cnt2", {32'd0, out_data2}, {32'd0, mon_e.data});
                    chk("out_sat_cnt2", {63'd0, out_sat2}, {63'd0, mon_e.sat});
                    if (mon_e.lat) chk("latency", 64'(cyc), 64'(mon_e.cyc + 2));
                    mon_xfer = mon_xfer + 1;
                    mon_sat  = mon_sat + longint'(mon_e.sat);
                end
            end else if (out_valid && !out_ready && sbq.size() != 0) begin
                chk("stall_hold", {32'd0, out_data}, {32'd0, sbq[0].data});
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] d, input logic [1:0] m, input exp_t e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push(e);
                return;
            end
        end
        chk("send_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    logic [IN_W-1:0]  dir_d[10] = '{8'hFF, 8'hFF, 8'h7F, 8'h0F, 8'h10, 8'hFF, 8'h07, 8'h08, 8'hF8, 8'h80};
    logic [1:0]       dir_m[10] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [OUT_W-1:0] dir_e[10] = '{32'h000000FF, 32'hFFFFFFFF, 32'h0000007F, 32'h0000000F, 32'h0000000F,
                                    32'h0000000F, 32'h00000007, 32'h00000007, 32'hFFFFFFF8, 32'hFFFFFFF8};
    logic             dir_s[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit pending;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        pending   = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
        chk("rst_xfer", {48'd0, xfer_cnt}, 64'd0);
        chk("rst_sat", {48'd0, sat_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_in_ready2", {63'd0, in_ready2}, 64'd1);

        // Directed conversions, back-to-back with latency tracking.
        for (int i = 0; i < 10; i++) send(dir_d[i], dir_m[i], mk(dir_e[i], dir_s[i], 1'b1));
        idle();
        drain();

        // Backpressure: A and B fill the pipe, C must wait.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'hA1, 2'd0, mk(32'h000000A1, 1'b0, 1'b0));
        send(8'hB2, 2'd1, mk(32'hFFFFFFB2, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_data = 8'h33;
        in_mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_c_accept", {63'd0, in_ready}, 64'd1);
        if (in_ready) push(mk(32'h0000000F, 1'b1, 1'b0));
        chk("bp_emit0", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_emit1", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        chk("bp_emit2", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

        // Counters: 5 transfers, 2 saturating.
        clr_pulse();
        send(8'h01, 2'd2, mk(32'h00000001, 1'b0, 1'b0));
        send(8'h10, 2'd2, mk(32'h0000000F, 1'b1, 1'b0));
        send(8'h05, 2'd0, mk(32'h00000005, 1'b0, 1'b0));
        send(8'hFF, 2'd2, mk(32'h0000000F, 1'b1, 1'b0));
        send(8'h80, 2'd1, mk(32'hFFFFFF80, 1'b0, 1'b0));
        idle();
        drain();
        chk("cnt_xfer5", {48'd0, xfer_cnt}, 64'd5);
        chk("cnt_sat2", {48'd0, sat_cnt}, 64'd2);
        chk("cnt2_xfer_wrap", {62'd0, xfer_cnt2}, 64'd1);
        chk("cnt2_sat2", {62'd0, sat_cnt2}, 64'd2);

        // Clear coinciding with a handshake.
        send(8'h33, 2'd0, mk(32'h00000033, 1'b0, 1'b0));
        idle();
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        chk("clr_hs_valid", {63'd0, out_valid}, 64'd1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_hs_xfer", {48'd0, xfer_cnt}, 64'd0);
        chk("clr_hs_sat", {48'd0, sat_cnt}, 64'd0);
        chk("clr_hs_xfer2", {62'd0, xfer_cnt2}, 64'd0);

        // Four saturating transfers: 2-bit counters wrap / stick.
        for (int i = 0; i < 4; i++) send(8'h40, 2'd3, mk(32'h00000007, 1'b1, 1'b0));
        idle();
        drain();
        chk("cnt2_sat_stick", {62'd0, sat_cnt2}, 64'd3);
        chk("cnt2_xfer_zero", {62'd0, xfer_cnt2}, 64'd0);
        chk("cnt_xfer4", {48'd0, xfer_cnt}, 64'd4);
        chk("cnt_sat4", {48'd0, sat_cnt}, 64'd4);

        // Randomized traffic with random backpressure.
        clr_pulse();
        mon_xfer = 0;
        mon_sat  = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(3) != 0);
            if (!pending) begin
                if ($urandom_range(3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = IN_W'($urandom);
                    in_mode  = 2'($urandom);
                    pending  = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                push(ref_conv(in_data, in_mode));
                pending = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rnd_xfer", {48'd0, xfer_cnt}, 64'(mon_xfer % 65536));
        chk("rnd_sat", {48'd0, sat_cnt}, 64'((mon_sat > 65535) ? 65535 : mon_sat));
        chk("rnd_xfer2", {62'd0, xfer_cnt2}, 64'(mon_xfer % 4));
        chk("rnd_sat2", {62'd0, sat_cnt2}, 64'((mon_sat > 3) ? 3 : mon_sat));

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(8'h11, 2'd0, mk(32'h00000011, 1'b0, 1'b0));
        send(8'h22, 2'd0, mk(32'h00000022, 1'b0, 1'b0));
        idle();
        @(negedge clk);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_valid2", {63'd0, out_valid2}, 64'd0);
        chk("arst_xfer", {48'd0, xfer_cnt}, 64'd0);
        chk("arst_sat", {48'd0, sat_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        chk("final_queue_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
